// File: rtl/regfile_nxm.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_nxm
//  Description : DEPTH x WIDTH storage array usable either as an addressed
//                register file (fifo_mode = 0) or as a FIFO (fifo_mode = 1).
//                The read port is a 3-state bus gated by 'read'.  In FIFO mode
//                the block keeps an occupancy count, full/empty decodes, and
//                sticky overflow/underflow flags.
//
//  Ports       : clk        rising-edge clock
//                reset      synchronous active-high reset
//                d          write / push data
//                q          read data (high-Z unless read == 1)
//                read       output enable for q
//                ra, wa     read / write address (addressed mode)
//                write      write strobe (addressed mode)
//                fifo_mode  0 = register file, 1 = FIFO
//                push, pop  FIFO requests
//                clr_flags  clears ovf / udf
//                full,empty FIFO status decoded from registered count
//                count      FIFO occupancy (0..DEPTH)
//                ovf, udf   sticky refused-push / refused-pop flags
//
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_nxm #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    input  logic             read,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    wa,
    input  logic             write,
    input  logic             fifo_mode,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_flags,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             ovf,
    output logic             udf
);

    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             r_mode;
    logic             r_ovf;
    logic             r_udf;

    logic             w_full;
    logic             w_empty;
    logic             w_mode_change;
    logic             w_fifo_active;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_ovf_err;
    logic             w_udf_err;
    logic             w_write_ok;
    logic [WIDTH-1:0] w_rd_word;

    assign w_full  = (r_count == c_full_count);
    assign w_empty = (r_count == '0);

    // A mode switch restarts the FIFO pointers; FIFO requests on that edge
    // are dropped so they cannot land on pointers that are being cleared.
    assign w_mode_change = (fifo_mode != r_mode);
    assign w_fifo_active = fifo_mode && !w_mode_change;

    // A simultaneous pop frees a slot, so a push into a full FIFO is accepted
    // when it is paired with a pop.  A pop on an empty FIFO is never
    // accepted, even alongside a push (no fall-through path).
    assign w_pop_ok  = w_fifo_active && pop && !w_empty;
    assign w_push_ok = w_fifo_active && push && (!w_full || w_pop_ok);
    assign w_ovf_err = w_fifo_active && push && !w_push_ok;
    assign w_udf_err = w_fifo_active && pop && !w_pop_ok;

    assign w_write_ok = !fifo_mode && write;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_mode   <= fifo_mode;
        end else begin
            r_mode <= fifo_mode;

            if (w_write_ok) begin
                r_mem[wa] <= d;
            end else if (w_push_ok) begin
                r_mem[r_wr_ptr] <= d;
            end

            if (w_mode_change) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                // DEPTH is a power of two, so pointer wrap is natural overflow.
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop_ok) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push_ok, w_pop_ok})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end

            // A new error in the same cycle as clr_flags wins.
            r_ovf <= (r_ovf && !clr_flags) || w_ovf_err;
            r_udf <= (r_udf && !clr_flags) || w_udf_err;
        end
    end

    always_comb begin
        w_rd_word = r_mem[ra];
        if (fifo_mode) begin
            w_rd_word = w_empty ? '0 : r_mem[r_rd_ptr];
        end
    end

    assign q     = (read == 1'b1) ? w_rd_word : {WIDTH{1'bz}};
    assign full  = w_full;
    assign empty = w_empty;
    assign count = r_count;
    assign ovf   = r_ovf;
    assign udf   = r_udf;

endmodule
`default_nettype wire
